// File: rtl/clk_ratio_pkg.sv
// Shared types and default constants for the clock ratio meter.
// Optional duty-cycle comparator is enabled by defining CLK_RATIO_DUTY_CHECK_EN.
package clk_ratio_pkg;

    localparam int DEFAULT_CNT_W    = 16;
    localparam int DEFAULT_DUTY_TOL = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/clk_ratio_edge_sync.sv
// Brings the measured signal into the clk domain and flags its rising/falling edges.
// Two flops resynchronize, the third delays by one cycle for edge detection.
module clk_ratio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain plus one history flop, cleared by reset so no edge is seen at start-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sig;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the division ratio and high/low split of a slow clock sampled by clk.
// A result is published one cycle after each rising edge that closes a full period.
// Define CLK_RATIO_DUTY_CHECK_EN to build the 50% duty comparator; otherwise duty_ok is 1.
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int DUTY_TOL = DEFAULT_DUTY_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             valid_out,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             duty_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_rise;
    logic             w_fall;

    state_t           r_state;
    state_t           w_nextState;

    logic             w_cntLoad;
    logic             w_cntInc;
    logic             w_latchHi;
    logic             w_publish;
    logic             w_timeout;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hiTmp;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_periodSat;

    logic             r_valid;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_highCnt;
    logic [CNT_W-1:0] r_lowCnt;
    logic             r_dutyOk;
    logic             r_timeout;

    clk_ratio_edge_sync u_edgeSync (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // State register; reset always lands in IDLE so a partial period is never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and datapath controls; an edge wins over the counter-full check.
    always_comb begin
        w_nextState = r_state;
        w_cntLoad   = 1'b0;
        w_cntInc    = 1'b0;
        w_latchHi   = 1'b0;
        w_publish   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_cntLoad   = 1'b1;
                    w_nextState = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_latchHi   = 1'b1;
                    w_cntLoad   = 1'b1;
                    w_nextState = LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_cntInc    = 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_publish   = 1'b1;
                    w_cntLoad   = 1'b1;
                    w_nextState = HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_cntInc    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Phase counter: loads 1 on the edge cycle itself so it counts sampled cycles of the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cntLoad) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_cntInc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Holds the high-phase length until the low phase closes the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hiTmp <= '0;
        end else if (w_latchHi) begin
            r_hiTmp <= r_cnt;
        end
    end

    assign w_sum       = {1'b0, r_hiTmp} + {1'b0, r_cnt};
    assign w_periodSat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];

    // Published results; they only change on a completed period and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_highCnt <= '0;
            r_lowCnt  <= '0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_period  <= w_periodSat;
                r_highCnt <= r_hiTmp;
                r_lowCnt  <= r_cnt;
            end
        end
    end

    // Sticky timeout: set when a phase overruns the counter, cleared by the next good result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_publish) begin
            r_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_timeout <= 1'b1;
        end
    end

`ifdef CLK_RATIO_DUTY_CHECK_EN
    logic [CNT_W-1:0] w_diff;

    // Larger-minus-smaller keeps the high/low difference free of unsigned wrap.
    always_comb begin
        w_diff = (r_hiTmp >= r_cnt) ? (r_hiTmp - r_cnt) : (r_cnt - r_hiTmp);
    end

    // Duty verdict is captured together with the rest of the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dutyOk <= 1'b0;
        end else if (w_publish) begin
            r_dutyOk <= (w_diff <= CNT_W'(DUTY_TOL));
        end
    end
`else
    // Without the comparator the verdict is simply asserted once out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dutyOk <= 1'b0;
        end else begin
            r_dutyOk <= 1'b1;
        end
    end
`endif

    assign valid_out = r_valid;
    assign period    = r_period;
    assign high_cnt  = r_highCnt;
    assign low_cnt   = r_lowCnt;
    assign duty_ok   = r_dutyOk;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter with a scoreboard of expected period results.
// Expected duty verdicts follow CLK_RATIO_DUTY_CHECK_EN when it is defined.
module tb_clk_ratio_meter;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             valid_out;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             duty_ok;
    logic             timeout;

    typedef struct {
        int h;
        int l;
        int interval;
    } exp_t;

    exp_t sbQueue[$];

    int checkCount     = 0;
    int passCount      = 0;
    int cycle          = 0;
    int lastValidCycle = 0;

    bit pendValid    = 1'b0;
    int pendH        = 0;
    int pendL        = 0;
    int pendInterval = 0;

    clk_ratio_meter dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .valid_out (valid_out),
        .period    (period),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .duty_ok   (duty_ok),
        .timeout   (timeout)
    );

    // Free-running measurement clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure the spacing of valid_out pulses.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic expDuty(input int h, input int l);
`ifdef CLK_RATIO_DUTY_CHECK_EN
        int d;
        d = (h >= l) ? (h - l) : (l - h);
        return (d <= 1);
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // The rising edge at the start of this period closes the pending one, if any.
    task automatic applyStimulus(input int h, input int l);
        int newInterval;
        newInterval = pendValid ? (h + l) : 0;
        if (pendValid) sbQueue.push_back('{pendH, pendL, pendInterval});
        pendValid    = 1'b1;
        pendH        = h;
        pendL        = l;
        pendInterval = newInterval;
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic holdHigh(input int n);
        if (pendValid) sbQueue.push_back('{pendH, pendL, pendInterval});
        pendValid = 1'b0;
        sig_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic driveLow(input int n);
        sig_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic closeAndDrain();
        int budget;
        if (pendValid) sbQueue.push_back('{pendH, pendL, pendInterval});
        pendValid = 1'b0;
        sig_in = 1'b1;
        budget = 10;
        while (sbQueue.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("drain", sbQueue.size(), 0);
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard consumer: every valid_out must match the oldest expected period.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_out) begin
            checkOutput("sb_nonempty", (sbQueue.size() > 0), 1);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("period", period, e.h + e.l);
                checkOutput("high_cnt", high_cnt, e.h);
                checkOutput("low_cnt", low_cnt, e.l);
                checkOutput("duty_ok", duty_ok, expDuty(e.h, e.l));
                checkOutput("timeout_on_valid", timeout, 0);
                if (e.interval != 0) checkOutput("valid_interval", cycle - lastValidCycle, e.interval);
            end
            lastValidCycle = cycle;
        end
    end

    initial begin
        sig_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_period", period, 0);
        checkOutput("rst_high", high_cnt, 0);
        checkOutput("rst_low", low_cnt, 0);
        checkOutput("rst_duty", duty_ok, 0);
        checkOutput("rst_timeout", timeout, 0);
        rst = 1'b0;
        driveLow(3);
`ifdef CLK_RATIO_DUTY_CHECK_EN
        checkOutput("idle_duty", duty_ok, 0);
`else
        checkOutput("idle_duty", duty_ok, 1);
`endif

        $display("[TB] 2 high / 2 low");
        repeat (5) applyStimulus(2, 2);
        $display("[TB] 3 high / 2 low");
        repeat (3) applyStimulus(3, 2);
        $display("[TB] 1 high / 4 low");
        repeat (3) applyStimulus(1, 4);
        $display("[TB] 2/2 switching to 5/5");
        repeat (2) applyStimulus(2, 2);
        repeat (3) applyStimulus(5, 5);

        $display("[TB] long high for timeout");
        holdHigh(65600);
        checkOutput("timeout_set", timeout, 1);
        checkOutput("period_hold", period, 10);
        checkOutput("high_hold", high_cnt, 5);
        driveLow(2);
        checkOutput("timeout_sticky", timeout, 1);
        repeat (3) applyStimulus(2, 2);
        checkOutput("timeout_clear", timeout, 0);

        $display("[TB] reset mid-low");
        repeat (2) applyStimulus(4, 4);
        if (pendValid) sbQueue.push_back('{pendH, pendL, pendInterval});
        pendValid = 1'b0;
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_queue", sbQueue.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", valid_out, 0);
        checkOutput("mid_rst_period", period, 0);
        checkOutput("mid_rst_high", high_cnt, 0);
        checkOutput("mid_rst_low", low_cnt, 0);
        checkOutput("mid_rst_duty", duty_ok, 0);
        checkOutput("mid_rst_timeout", timeout, 0);
        rst = 1'b0;
        driveLow(2);
        repeat (3) applyStimulus(4, 4);
        closeAndDrain();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 Parameter CNT_W SHALL default to 16; it sets the width of all count outputs and the internal counter.
REQ-002 Parameter DUTY_TOL SHALL default to 1; it is the maximum allowed |high_cnt - low_cnt| for a 50% duty verdict.
REQ-003 Port clk SHALL be an input, 1 bit, the single measurement clock; all logic SHALL use its rising edge only.
REQ-004 Port rst SHALL be an input, 1 bit, synchronous active-high reset.
REQ-005 Port sig_in SHALL be an input, 1 bit, the divided clock under measurement, sampled as data.
REQ-006 Port valid_out SHALL be an output, 1 bit, a one-cycle pulse marking fresh results.
REQ-007 Port period SHALL be an output, CNT_W bits, the measured division ratio N in clk cycles.
REQ-008 Port high_cnt SHALL be an output, CNT_W bits, the clk cycles sig_in was sampled high in the last full period.
REQ-009 Port low_cnt SHALL be an output, CNT_W bits, the clk cycles sig_in was sampled low in the last full period.
REQ-010 Port duty_ok SHALL be an output, 1 bit, high when the last period met the duty tolerance.
REQ-011 Port timeout SHALL be an output, 1 bit, a sticky flag set when sig_in shows no edge within the counter range.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 FSM states SHALL be IDLE, HIGH and LOW; reset enters IDLE.
REQ-014 IDLE: on rise, go to HIGH and load the counter with 1; other cycles hold.
REQ-015 HIGH: on fall, latch hi_tmp = counter, load the counter with 1, go to LOW; otherwise increment the counter.
REQ-016 LOW: on rise, register high_cnt = hi_tmp, low_cnt = counter, period = hi_tmp + counter, and duty_ok; assert valid_out for exactly one cycle; load the counter with 1; go to HIGH.
REQ-017 LOW: on any other cycle, increment the counter.
REQ-018 The first partial period after IDLE SHALL never produce valid_out; the first valid_out follows one complete high+low period.
REQ-019 Latency: if sig_in is first sampled high at edge k and closes a period, valid_out and the new outputs SHALL be visible after edge k+2.
REQ-020 period SHALL be computed in CNT_W+1 bits and saturate to 2^CNT_W-1.
REQ-021 duty_ok SHALL be 1 when |high - low| <= DUTY_TOL; the subtraction SHALL be unsigned-safe (compare the larger minus the smaller).
REQ-022 When the counter reaches 2^CNT_W-1 in HIGH or LOW, timeout SHALL set, the FSM SHALL go to IDLE, and no valid_out SHALL be issued.
REQ-023 timeout SHALL clear only on the next valid_out or on rst.
REQ-024 period, high_cnt, low_cnt and duty_ok SHALL hold their last values between valid_out pulses.

Reset
REQ-025 On rst: s1, s2, s3 = 0; FSM = IDLE; counter, hi_tmp, period, high_cnt, low_cnt = 0; valid_out, duty_ok, timeout = 0.
REQ-026 rst asserted mid-period SHALL discard the partial measurement; after release the block SHALL resynchronize from IDLE per REQ-018.

Configuration
REQ-027 With macro CLK_RATIO_DUTY_CHECK_EN defined, duty_ok SHALL follow REQ-021.
REQ-028 Without CLK_RATIO_DUTY_CHECK_EN, duty_ok SHALL be driven constant 1 after reset, the comparator SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package clk_ratio_pkg SHALL hold the FSM state typedef (IDLE, HIGH, LOW) and the default CNT_W and DUTY_TOL constants.
REQ-030 Sub-module clk_ratio_edge_sync SHALL contain s1..s3 and the rise/fall outputs; the FSM, counter and outputs SHALL live in clk_ratio_meter.

Verification
REQ-031 Drive sig_in 2 high / 2 low repeatedly -> from the second period on: period=4, high_cnt=2, low_cnt=2, duty_ok=1, one valid_out per 4 cycles.
REQ-032 Drive 3 high / 2 low (odd N=5) -> period=5, high_cnt=3, low_cnt=2, duty_ok=1 (DUTY_TOL=1).
REQ-033 Drive 1 high / 4 low -> period=5, duty_ok=0; rebuild without CLK_RATIO_DUTY_CHECK_EN -> duty_ok=1.
REQ-034 Hold sig_in high for more than 65535 cycles (CNT_W=16) -> timeout=1, no valid_out; resume 2/2 toggling -> the first valid_out clears timeout.
REQ-035 Assert rst mid-LOW during 4/4 toggling -> all outputs 0 next cycle; first valid_out only after a full period following release.
REQ-036 Switch sig_in from 2/2 to 5/5 toggling -> the next complete period reports period=10, and no valid_out reports a mixed value other than the transition period.
